serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - b_in, with borrow-out.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic b_in_i,
    output logic d_o,
    output logic b_out_o
);

    // Difference bit and borrow generated when a is smaller than b + b_in.
    always_comb begin
        d_o     = a_i ^ b_i ^ b_in_i;
        b_out_o = (~a_i & b_i) | (~(a_i ^ b_i) & b_in_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - B_IN, LSB first, through one full-subtractor cell.
// Latency: WIDTH cycles from the accepting edge to DONE; next op can start in the DONE cycle.
// Backpressure: START is only sampled in IDLE or DONE; requests during RUN are dropped.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             b_out_o,
    output logic             ovf_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-2:0]   part_q;
    logic [WIDTH-1:0]   res_d;
    logic               bor_q;
    logic               bor_d;
    logic               bit_d;
    logic               a_msb_q;
    logic               b_msb_q;
    logic [WIDTH-1:0]   d_q;
    logic               b_out_q;
    logic               ovf_q;
    logic               accept;
    logic               last;

    // The single arithmetic slice, fed by the operand LSBs and the borrow flop.
    full_subtractor u_fs (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .b_in_i  (bor_q),
        .d_o     (bit_d),
        .b_out_o (bor_d)
    );

    // Acceptance, last-bit detect, counter increment and the result seen with the current bit on top.
    always_comb begin
        accept = start_i && ((state_q == IDLE) || (state_q == DONE));
        last   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        res_d  = {bit_d, part_q};
    end

    // Control FSM with registered BUSY/DONE; DONE is held for exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                    done_q <= 1'b0;
                end
                RUN: begin
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand shifters, borrow flop and bit counter: load on accept, shift right each RUN cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            part_q  <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            bor_q   <= b_in_i;
            cnt_q   <= '0;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
        end else if (state_q == RUN) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            bor_q  <= bor_d;
            part_q <= res_d[WIDTH-1:1];
            cnt_q  <= cnt_d;
        end
    end

    // Visible result registers only update on the final bit, so partial sums never leak out.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            d_q     <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (last) begin
            d_q     <= res_d;
            b_out_q <= bor_d;
            ovf_q   <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign d_o     = d_q;
    assign b_out_o = b_out_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: countdown timing model plus arithmetic reference, directed and random ops.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             b_in  = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             ovf;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .b_in_i  (b_in),
        .busy_o  (busy),
        .done_o  (done),
        .d_o     (d),
        .b_out_o (b_out),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: plain integer subtraction modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] ref_d(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
        longint r;
        r = longint'(x) - longint'(y) - longint'(bi);
        return r[WIDTH-1:0];
    endfunction

    function automatic logic ref_bo(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        return longint'(x) < (longint'(y) + longint'(bi));
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        logic [WIDTH-1:0] r;
        r = ref_d(x, y, bi);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing model: an accepted op completes WIDTH edges later; nothing is accepted while one is pending.
    int               rem   = 0;
    int               n_ops = 0;
    logic             m_busy = 1'b0, m_done = 1'b0, m_bo = 1'b0, m_ovf = 1'b0;
    logic [WIDTH-1:0] m_d = '0;
    logic [WIDTH-1:0] p_d = '0;
    logic             p_bo = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_d    <= '0;
            m_bo   <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (rem > 0) begin
            rem    <= rem - 1;
            m_busy <= (rem > 1);
            m_done <= (rem == 1);
            if (rem == 1) begin
                m_d   <= p_d;
                m_bo  <= p_bo;
                m_ovf <= p_ovf;
                n_ops <= n_ops + 1;
            end
        end else begin
            m_done <= 1'b0;
            m_busy <= start;
            if (start) begin
                rem   <= WIDTH;
                p_d   <= ref_d(a, b, b_in);
                p_bo  <= ref_bo(a, b, b_in);
                p_ovf <= ref_ovf(a, b, b_in);
            end
        end
    end

    // Every cycle: DUT outputs against the model, and BUSY/DONE exclusivity.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("d", 64'(d), 64'(m_d));
            chk("b_out", 64'(b_out), 64'(m_bo));
            chk("ovf", 64'(ovf), 64'(m_ovf));
            chk("busy_and_done", 64'(busy & done), 64'(0));
        end
    end

    // Directed op with literal expectations, latency and one-cycle DONE width.
    task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ibi,
                      input logic [WIDTH-1:0] ed, input logic eb, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        a = ia; b = ib; b_in = ibi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); b_in = 1'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(WIDTH));
        chk({nm, "_d"}, 64'(d), 64'(ed));
        chk({nm, "_b_out"}, 64'(b_out), 64'(eb));
        chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({nm, "_done_width"}, 64'(done), 64'(0));
        chk({nm, "_d_hold"}, 64'(d), 64'(ed));
    endtask

    initial begin
        int g;
        int ops_before;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_d", 64'(d), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "sub_5_3");
        op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "sub_3_5");
        op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_0_0_bin");

        // START pulsed mid-RUN with other operands must not disturb the first result.
        @(negedge clk);
        a = 8'h05; b = 8'h03; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h11; b_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 3;
        while (!done && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("ignore_latency", 64'(g), 64'(WIDTH));
        chk("ignore_d", 64'(d), 64'(8'h02));
        repeat (3) @(negedge clk);
        chk("ignore_no_second_op", 64'(busy | done), 64'(0));

        // START held high: the second op is accepted in the DONE cycle, WIDTH+1 cycles apart.
        @(negedge clk);
        a = 8'h10; b = 8'h01; b_in = 1'b0; start = 1'b1;
        g = 0;
        while (!done && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("b2b_first_d", 64'(d), 64'(8'h0F));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_again", 64'(busy), 64'(1));
        g = 1;
        while (!done && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("b2b_gap", 64'(g), 64'(WIDTH + 1));
        chk("b2b_second_d", 64'(d), 64'(8'h0F));
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN aborts and clears all outputs.
        a = 8'h7E; b = 8'h01; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_d", 64'(d), 64'(0));
        chk("abort_b_out", 64'(b_out), 64'(0));
        chk("abort_ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", 64'(busy | done), 64'(0));
        op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "after_abort");

        // Random traffic: frequent START, operands changing every cycle.
        ops_before = n_ops;
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            b_in  = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
        chk("random_ops_completed", 64'(n_ops - ops_before > 1000), 64'(1));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, required completion");
        $fatal(1, "watchdog");
    end

endmodule
